// File: rtl/cvbs_output_stage_if.sv
// Sample, sync and configuration bus of the CVBS output mixer.
// master drives samples/config and reads the DAC code; slave is the mixer.
interface cvbs_output_stage_if #(
    parameter int OUT_W   = 10,
    parameter int IN_W    = 8,
    parameter int NUM_STD = 4
);
    localparam int SW = (NUM_STD > 1) ? $clog2(NUM_STD) : 1;

    logic                   sync;
    logic                   newframe;
    logic [SW-1:0]          std_sel;
    logic [IN_W-1:0]        luma;
    logic signed [IN_W-1:0] chroma;
    logic                   cfg_we;
    logic [3:0]             cfg_addr;
    logic [15:0]            cfg_wdata;
    logic [OUT_W-1:0]       video;
    logic                   video_overflow;
    logic [15:0]            ovf_count;
    logic [15:0]            unf_count;

    modport master (
        output sync, newframe, std_sel, luma, chroma,
        output cfg_we, cfg_addr, cfg_wdata,
        input  video, video_overflow, ovf_count, unf_count
    );

    modport slave (
        input  sync, newframe, std_sel, luma, chroma,
        input  cfg_we, cfg_addr, cfg_wdata,
        output video, video_overflow, ovf_count, unf_count
    );
endinterface

// File: rtl/cvbs_output_stage.sv
// CVBS output mixer: gain/black/chroma sum, DAC saturation, ramped sync edges.
// Optional CVBS_OVF_COUNT_EN adds per-frame overflow/underflow counters.
module cvbs_output_stage #(
    parameter int OUT_W    = 10,
    parameter int IN_W     = 8,
    parameter int FRAC_W   = 7,
    parameter int RAMP_LEN = 4,
    parameter int NUM_STD  = 4
) (
    input logic              clk,
    input logic              reset,
    cvbs_output_stage_if.slave bus
);
    localparam int GW    = FRAC_W + 1;
    localparam int SUM_W = OUT_W + 3;
    localparam int UP    = OUT_W - IN_W;
    localparam int SH    = $clog2(RAMP_LEN);
    localparam int KW    = (RAMP_LEN > 1) ? $clog2(RAMP_LEN) : 1;
    localparam int RW    = OUT_W + KW;

    localparam logic [OUT_W-1:0] BLACK_RST = OUT_W'(52 << (OUT_W - 8));
    localparam logic [GW-1:0]    GAIN_RST  = GW'(1 << FRAC_W);
    localparam logic [KW-1:0]    K_LAST    = KW'(RAMP_LEN - 1);
    localparam logic [KW-1:0]    K_ONE     = KW'(1);
    localparam logic signed [SUM_W-1:0] MAXV = SUM_W'((1 << OUT_W) - 1);

    typedef enum logic [1:0] {ACTIVE, FALL, SYNC, RISE} state_t;

    logic [GW-1:0]    gain_tab  [NUM_STD];
    logic [OUT_W-1:0] black_tab [NUM_STD];

    logic unused_cfg;
    assign unused_cfg = ^{bus.cfg_addr[2], bus.cfg_wdata[15:OUT_W]};

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_STD; i++) begin
                gain_tab[i]  <= GAIN_RST;
                black_tab[i] <= BLACK_RST;
            end
        end else if (bus.cfg_we && int'(bus.cfg_addr[1:0]) < NUM_STD) begin
            if (bus.cfg_addr[3])
                black_tab[bus.cfg_addr[1:0]] <= bus.cfg_wdata[OUT_W-1:0];
            else
                gain_tab[bus.cfg_addr[1:0]] <= bus.cfg_wdata[FRAC_W:0];
        end
    end

    logic                   s1_sync, s1_nf;
    logic [IN_W-1:0]        s1_luma;
    logic signed [IN_W-1:0] s1_chroma;
    logic [GW-1:0]          s1_gain;
    logic [OUT_W-1:0]       s1_black;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_sync   <= 1'b1;
            s1_nf     <= 1'b0;
            s1_luma   <= '0;
            s1_chroma <= '0;
            s1_gain   <= GAIN_RST;
            s1_black  <= BLACK_RST;
        end else begin
            s1_sync   <= bus.sync;
            s1_nf     <= bus.newframe;
            s1_luma   <= bus.luma;
            s1_chroma <= bus.chroma;
            s1_gain   <= gain_tab[bus.std_sel];
            s1_black  <= black_tab[bus.std_sel];
        end
    end

    logic [IN_W+GW-1:0] prod;
    logic [SUM_W-1:0]   blk_x, scl_x, chr_x, sum_c;

    assign prod  = s1_luma * s1_gain;
    assign blk_x = SUM_W'(s1_black);
    assign scl_x = SUM_W'(prod >> FRAC_W) << UP;
    assign chr_x = SUM_W'(s1_chroma) << UP;
    assign sum_c = blk_x + scl_x + chr_x;

    logic                    s2_sync, s2_nf;
    logic signed [SUM_W-1:0] s2_sum;
    logic [OUT_W-1:0]        s2_black;

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_sync  <= 1'b1;
            s2_nf    <= 1'b0;
            s2_sum   <= '0;
            s2_black <= BLACK_RST;
        end else begin
            s2_sync  <= s1_sync;
            s2_nf    <= s1_nf;
            s2_sum   <= sum_c;
            s2_black <= s1_black;
        end
    end

    state_t           state_q, state_n;
    logic [KW-1:0]    k_q, k_n;
    logic [OUT_W-1:0] video_q, video_n, sat_c;
    logic [RW-1:0]    rprod;
    logic             ovf_c, unf_c, ev_ovf, ev_unf, vo_q;

    assign ovf_c = s2_sum > MAXV;
    assign unf_c = s2_sum[SUM_W-1];
    assign sat_c = unf_c ? '0 : (ovf_c ? '1 : s2_sum[OUT_W-1:0]);
    assign rprod = RW'(s2_black) * RW'(k_n);

    // k/state describe the sample being emitted this edge, not the next one
    always_comb begin
        state_n = state_q;
        k_n     = k_q;
        if (RAMP_LEN == 1) begin
            state_n = s2_sync ? SYNC : ACTIVE;
            k_n     = '0;
        end else begin
            unique case (state_q)
                ACTIVE: if (s2_sync) begin
                    state_n = FALL;
                    k_n     = K_LAST;
                end
                SYNC: if (!s2_sync) begin
                    state_n = RISE;
                    k_n     = K_ONE;
                end
                FALL, RISE: if (s2_sync) begin
                    if (k_q == K_ONE) begin
                        state_n = SYNC;
                        k_n     = '0;
                    end else begin
                        state_n = FALL;
                        k_n     = k_q - K_ONE;
                    end
                end else begin
                    if (k_q == K_LAST) begin
                        state_n = ACTIVE;
                        k_n     = '0;
                    end else begin
                        state_n = RISE;
                        k_n     = k_q + K_ONE;
                    end
                end
                default: ;
            endcase
        end
        video_n = OUT_W'(rprod >> SH);
        if (state_n == ACTIVE) video_n = sat_c;
        else if (state_n == SYNC) video_n = '0;
        ev_ovf = (state_n == ACTIVE) && ovf_c;
        ev_unf = (state_n == ACTIVE) && unf_c;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SYNC;
            k_q     <= '0;
            video_q <= '0;
            vo_q    <= 1'b0;
        end else begin
            state_q <= state_n;
            k_q     <= k_n;
            video_q <= video_n;
            if (ev_ovf || ev_unf) vo_q <= 1'b1;
            else if (s2_nf) vo_q <= 1'b0;
        end
    end

    assign bus.video          = video_q;
    assign bus.video_overflow = vo_q;

`ifdef CVBS_OVF_COUNT_EN
    logic [15:0] ovf_int, unf_int, ovf_out, unf_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_int <= '0;
            unf_int <= '0;
            ovf_out <= '0;
            unf_out <= '0;
        end else if (s2_nf) begin
            ovf_out <= ovf_int;
            unf_out <= unf_int;
            ovf_int <= {15'd0, ev_ovf};
            unf_int <= {15'd0, ev_unf};
        end else begin
            if (ev_ovf && ovf_int != 16'hFFFF) ovf_int <= ovf_int + 16'd1;
            if (ev_unf && unf_int != 16'hFFFF) unf_int <= unf_int + 16'd1;
        end
    end

    assign bus.ovf_count = ovf_out;
    assign bus.unf_count = unf_out;
`else
    assign bus.ovf_count = '0;
    assign bus.unf_count = '0;
`endif
endmodule

// File: tb/tb_cvbs_output_stage.sv
// Bench for cvbs_output_stage: ramp-level reference model plus directed literals.
// Honours CVBS_OVF_COUNT_EN for the expected counter values.
module tb_cvbs_output_stage;
    localparam int RL   = 4;
    localparam int VMAX = 1023;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cvbs_output_stage_if #(.OUT_W(10), .IN_W(8), .NUM_STD(4)) bus ();

    cvbs_output_stage dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: sync edges seen as a level 0..RL (0 = tip, RL = active video)
    typedef struct {
        bit sy;
        bit nf;
        int s;
        int blk;
    } rec_t;

    int   gain_m [4];
    int   black_m[4];
    rec_t pipe[$];
    int   lvl, vid_m, oi_m, ui_m, oc_m, uc_m;
    bit   vo_m, mvalid;

    always @(posedge clk) begin
        rec_t r, o;
        bit eo, eu;
        int idx;
        mvalid = 1'b1;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                gain_m[i]  = 128;
                black_m[i] = 208;
            end
            pipe = {};
            r.sy = 1'b1; r.nf = 1'b0; r.s = 0; r.blk = 208;
            pipe.push_back(r);
            pipe.push_back(r);
            lvl = 0; vid_m = 0; vo_m = 1'b0;
            oi_m = 0; ui_m = 0; oc_m = 0; uc_m = 0;
        end else begin
            r.sy  = bus.sync;
            r.nf  = bus.newframe;
            r.blk = black_m[bus.std_sel];
            r.s   = r.blk + ((int'(bus.luma) * gain_m[bus.std_sel]) >> 7) * 4
                    + int'($signed(bus.chroma)) * 4;
            pipe.push_back(r);
            o = pipe.pop_front();
            if (o.sy) lvl = (lvl > 0) ? lvl - 1 : 0;
            else      lvl = (lvl < RL) ? lvl + 1 : RL;
            eo = (lvl == RL) && (o.s > VMAX);
            eu = (lvl == RL) && (o.s < 0);
            if (lvl == RL) vid_m = (o.s < 0) ? 0 : ((o.s > VMAX) ? VMAX : o.s);
            else           vid_m = (o.blk * lvl) / RL;
            if (eo || eu) vo_m = 1'b1;
            else if (o.nf) vo_m = 1'b0;
`ifdef CVBS_OVF_COUNT_EN
            if (o.nf) begin
                oc_m = oi_m; uc_m = ui_m;
                oi_m = int'(eo); ui_m = int'(eu);
            end else begin
                if (eo && oi_m < 65535) oi_m++;
                if (eu && ui_m < 65535) ui_m++;
            end
`endif
            if (bus.cfg_we) begin
                idx = int'(bus.cfg_addr[1:0]);
                if (bus.cfg_addr[3]) black_m[idx] = int'(bus.cfg_wdata) & 16'h03FF;
                else                 gain_m[idx]  = int'(bus.cfg_wdata) & 16'h00FF;
            end
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            chk("video", int'(bus.video), vid_m);
            chk("overflow_flag", int'(bus.video_overflow), int'(vo_m));
            chk("ovf_count", int'(bus.ovf_count), oc_m);
            chk("unf_count", int'(bus.unf_count), uc_m);
        end
    end

    int exq[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // drives exq.size()+2 cycles; output of input i is visible after input i+2
    task automatic seq(input string nm, input bit [7:0] sp, input int np,
                       input int lu, input int ch);
        int n;
        n = exq.size();
        for (int i = 0; i < n + 2; i++) begin
            bus.sync   = (i < np) ? sp[i] : sp[np-1];
            bus.luma   = 8'(lu);
            bus.chroma = 8'(ch);
            step();
            if (i >= 2) chk(nm, int'(bus.video), exq[i-2]);
        end
    endtask

    task automatic cfg_wr(input logic [3:0] a, input logic [15:0] d);
        bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_wdata = d;
        step();
        bus.cfg_we = 1'b0;
    endtask

    task automatic drive1(input bit nf, input int lu, input int ch);
        bus.sync = 1'b0; bus.newframe = nf;
        bus.luma = 8'(lu); bus.chroma = 8'(ch);
        step();
        bus.newframe = 1'b0;
    endtask

    initial begin
        bus.sync = 1'b1; bus.newframe = 1'b0; bus.std_sel = '0;
        bus.luma = '0; bus.chroma = '0;
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
        rst = 1'b1;
        repeat (3) step();
        chk("reset_video", int'(bus.video), 0);
        chk("reset_flag", int'(bus.video_overflow), 0);
        chk("reset_ovf", int'(bus.ovf_count), 0);
        chk("reset_unf", int'(bus.unf_count), 0);
        rst = 1'b0;
        repeat (4) step();
        chk("idle_sync", int'(bus.video), 0);

        exq = '{52, 104, 156, 608, 608};
        seq("sync_fall", 8'h00, 1, 100, 0);
        exq = '{156, 104, 52, 0, 0};
        seq("sync_rise", 8'hFF, 1, 100, 0);
        exq = '{52, 104, 156, 608};
        seq("rise_again", 8'h00, 1, 100, 0);
        exq = '{156, 104, 156, 608, 608};
        seq("short_pulse", 8'h03, 3, 100, 0);
        exq = '{0, 0};
        seq("underflow", 8'h00, 1, 0, -128);
        chk("underflow_flag", int'(bus.video_overflow), 1);

        cfg_wr(4'h0, 16'd255);
        exq = '{1023, 1023};
        seq("overflow", 8'h00, 1, 255, 0);

        drive1(1'b1, 100, 0);
        repeat (5) drive1(1'b0, 255, 0);
        repeat (3) drive1(1'b0, 0, -128);
        drive1(1'b1, 100, 0);
        drive1(1'b0, 100, 0);
        drive1(1'b0, 100, 0);
`ifdef CVBS_OVF_COUNT_EN
        chk("frame_ovf", int'(bus.ovf_count), 5);
        chk("frame_unf", int'(bus.unf_count), 3);
`else
        chk("frame_ovf", int'(bus.ovf_count), 0);
        chk("frame_unf", int'(bus.unf_count), 0);
`endif
        chk("frame_flag", int'(bus.video_overflow), 0);

        cfg_wr(4'h1, 16'd64);
        bus.std_sel = 2'd1;
        exq = '{608, 608};
        seq("gain1", 8'h00, 1, 200, 0);
        bus.std_sel = 2'd0;

        exq = '{156};
        seq("fall_start", 8'hFF, 1, 100, 0);
        rst = 1'b1;
        step();
        chk("reset_mid_fall", int'(bus.video), 0);
        rst = 1'b0;
        bus.sync = 1'b1;
        repeat (5) step();
        chk("post_reset_sync", int'(bus.video), 0);
        exq = '{52, 104, 156, 608};
        seq("post_reset_rise", 8'h00, 1, 100, 0);

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(7) == 0) bus.sync = ~bus.sync;
            bus.luma      = 8'($urandom);
            bus.chroma    = 8'($urandom);
            bus.std_sel   = 2'($urandom);
            bus.newframe  = ($urandom_range(47) == 0);
            bus.cfg_we    = ($urandom_range(15) == 0);
            bus.cfg_addr  = 4'($urandom);
            bus.cfg_wdata = 16'($urandom);
            rst           = ($urandom_range(599) == 0);
            step();
        end
        rst = 1'b0;
        bus.cfg_we = 1'b0;
        bus.newframe = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cvbs_output_stage.md
# cvbs_output_stage

Parametrised final mixing stage for the composite video path. It takes filtered luma and modulated chroma, applies a per-standard luma gain and black level, and adds chroma into a wide signed sum. The sum is saturated to a configurable DAC width, and sync edges are shaped into linear ramps instead of hard steps. It replaces the fixed 8-bit, wrap-to-zero summation at the output of the encoder and adds per-frame overflow/underflow statistics.

## Interface
Parameters:
- OUT_W, 10: DAC output width; must be ≥ IN_W and ≥ 8.
- IN_W, 8: luma and chroma input width.
- FRAC_W, 7: fractional bits of the luma gain; gain width is FRAC_W+1.
- RAMP_LEN, 4: sync edge length in cycles; must be a power of two, ≥ 1.
- NUM_STD, 4: number of per-standard configuration entries.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- sync  in  1  1 = sync tip requested.
- newframe  in  1  one-cycle frame start strobe.
- std_sel  in  $clog2(NUM_STD)  selects the gain and black-level entry.
- luma  in  IN_W  unsigned, filtered luma.
- chroma  in  IN_W  signed, modulated chroma.
- cfg_we  in  1  configuration write strobe.
- cfg_addr  in  4  [3] 0 = gain, 1 = black level; [1:0] entry index.
- cfg_wdata  in  16  write data, LSB-aligned.
- video  out  OUT_W  DAC code.
- video_overflow  out  1  sticky: saturation occurred in the current frame.
- ovf_count  out  16  high-side saturations in the previous frame.
- unf_count  out  16  low-side saturations in the previous frame.

## Operation
- Stage 1 registers luma, chroma, sync, newframe and std_sel. It also reads gain[std_sel] and black[std_sel].
- Stage 2 computes the sum:
  - scaled = ((luma*gain) >> FRAC_W) << (OUT_W-IN_W).
  - s = black + scaled + (sign-extended chroma << (OUT_W-IN_W)).
  - s is signed, OUT_W+3 bits wide, so the sum cannot wrap.
- Stage 3 saturates and applies the edge state machine:
  - Saturation: s < 0 gives 0 and an underflow event; s > 2^OUT_W-1 gives 2^OUT_W-1 and an overflow event.
  - Saturation events are counted only in ACTIVE state.
- Edge state machine, with step k in 0..RAMP_LEN-1:
  - ACTIVE: output the saturated s. On sync=1, go to FALL with k=RAMP_LEN-1.
  - FALL: output (black*k)>>log2(RAMP_LEN) and decrement k. After k=1, go to SYNC. If sync returns to 0 mid-ramp, go to RISE keeping the current k.
  - SYNC: output 0. On sync=0, go to RISE with k=1.
  - RISE: output (black*k)>>log2(RAMP_LEN) and increment k. After k=RAMP_LEN-1, go to ACTIVE. If sync returns to 1 mid-ramp, go to FALL keeping the current k.
  - With RAMP_LEN=1 there are no ramp states: sync selects 0 or s directly.
- Ramps use black of the std_sel value registered alongside the sample.
- Configuration writes:
  - A write lands in the table on the edge where cfg_we is sampled. It applies from the next stage-1 read onward.
  - Indexes ≥ NUM_STD are ignored.
  - Gain takes cfg_wdata[FRAC_W:0]; black takes cfg_wdata[OUT_W-1:0].
- video_overflow:
  - Set by any saturation event.
  - Cleared by newframe at stage 3.
  - If an event coincides with newframe, the flag is set and belongs to the new frame.

## Timing
- Latency is 3 cycles from input to video, identical for data and for sync-driven ramps.
  - Example: sync rising at input cycle n produces the first FALL sample at n+3.
- newframe is pipelined alongside the data and acts at stage 3.
- Reset values:
  - video = 0, state = SYNC, k = 0, video_overflow = 0, ovf_count = unf_count = 0.
  - Every gain = 1<<FRAC_W; every black = 52<<(OUT_W-8).
  - Pipelined sync = 1 and newframe = 0, so releasing reset does not produce a spurious edge.
- Reset asserted mid-ramp or mid-frame aborts immediately to the reset state, with no partial counts kept.
- There is no backpressure: one sample is accepted every cycle.

## Configuration
- CVBS_OVF_COUNT_EN defined:
  - Two internal 16-bit counters, saturating at 0xFFFF, count overflow and underflow events.
  - At stage-3 newframe, the internal values are copied to ovf_count/unf_count.
  - The counters then restart at 1 if that cycle has an event of their kind, otherwise at 0.
- CVBS_OVF_COUNT_EN undefined:
  - The counters are not synthesised and ovf_count/unf_count are constant 0.
  - video_overflow behaves identically in both builds.

## Test plan
All scenarios use default parameters; black reset value is 208.
- Unity gain, active state, luma=100, chroma=0 -> video=608 three cycles later.
- luma=0, chroma=-128 -> video=0 and video_overflow=1; luma=255 with gain 255 -> video=1023.
- Sync rising at cycle n -> video 156, 104, 52, 0 at n+3..n+6.
- Sync falling -> video 52, 104, 156, then the active value.
- Sync pulse of 2 cycles:
  - The FALL ramp reverses mid-ramp into RISE without ever reaching 0.
  - Output sequence is 156, 104, 156, then the active value.
- Counters (CVBS_OVF_COUNT_EN defined):
  - Drive 5 overflows and 3 underflows, then newframe -> ovf_count=5, unf_count=3, video_overflow=0.
  - Repeat with the macro undefined -> both counts stay 0.
- cfg write gain[1]=64 with std_sel=1, luma=200 -> video=608.
- Reset asserted mid-FALL -> video=0 on the next cycle; after release, state SYNC and no ramp until sync falls.
